// File: rtl/fullyconn_nxm_dbuf.sv
// fullyconn_nxm_dbuf: N-input, M-output fully connected switch cell.
// Configuration shifts serially into a shadow register. It moves to the
// active register only on an accepted commit, so a new configuration can be
// loaded in the background while live routes stay undisturbed.
module fullyconn_nxm_dbuf #(
    parameter int size = 32,
    parameter int NIN  = 5,
    parameter int NOUT = 2,
    localparam int SELW = $clog2(NIN + 1),
    localparam int CW   = NOUT * SELW
) (
    input  logic                 config_clk,
    input  logic                 config_reset,
    input  logic                 config_in,
    input  logic                 config_en,
    input  logic                 config_commit,
    output logic                 config_out,
    input  logic [NIN*size-1:0]  in_bus,
    output logic [NOUT*size-1:0] out_bus,
    output logic                 cfg_loaded,
    output logic                 cfg_ack
);

    localparam int CNTW = $clog2(CW + 1);

    logic [CW-1:0]   shadow;
    logic [CW-1:0]   active;
    logic [CNTW-1:0] bit_cnt;
    logic            commit_ok;

    // A commit only takes effect once a complete word sits in the shadow.
    assign cfg_loaded = (bit_cnt == CNTW'(CW));
    assign commit_ok  = config_commit && cfg_loaded;

    // The chain continues from the oldest shadow bit.
    assign config_out = shadow[CW-1];

    // Shadow chain: first bit shifted in ends up at the MSB.
    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) begin
            shadow <= '0;
        end else if (config_en) begin
            shadow <= {shadow[CW-2:0], config_in};
        end
    end

    // Bit counter: saturates at CW; an accepted commit restarts it, counting
    // a shift that lands on the same edge.
    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) begin
            bit_cnt <= '0;
        end else if (commit_ok) begin
            bit_cnt <= config_en ? CNTW'(1) : '0;
        end else if (config_en && !cfg_loaded) begin
            bit_cnt <= bit_cnt + CNTW'(1);
        end
    end

    // Active register takes the pre-edge shadow on commit; ack follows one cycle later.
    always_ff @(posedge config_clk or posedge config_reset) begin
        if (config_reset) begin
            active  <= '0;
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= commit_ok;
            if (commit_ok) begin
                active <= shadow;
            end
        end
    end

    for (genvar j = 0; j < NOUT; j++) begin : g_out
        logic [SELW-1:0] sel;
        logic [size-1:0] out_val;

        assign sel = active[j*SELW +: SELW];

        // Output mux: select codes at or above NIN drive zero.
        always_comb begin
            out_val = '0;
            for (int k = 0; k < NIN; k++) begin
                if (sel == SELW'(k)) begin
                    out_val = in_bus[k*size +: size];
                end
            end
        end

        assign out_bus[j*size +: size] = out_val;
    end

endmodule

// File: tb/tb_fullyconn_nxm_dbuf.sv
// Testbench for fullyconn_nxm_dbuf (size=32, NIN=5, NOUT=2, CW=6).
module tb_fullyconn_nxm_dbuf;

    localparam logic [31:0] I0 = 32'hA5A5A5A5;
    localparam logic [31:0] I1 = 32'h11111111;
    localparam logic [31:0] I2 = 32'h22222222;
    localparam logic [31:0] I3 = 32'h33333333;
    localparam logic [31:0] I4 = 32'h44444444;
    localparam logic [31:0] Z  = 32'h00000000;

    logic         config_clk = 1'b0;
    logic         config_reset;
    logic         config_in;
    logic         config_en;
    logic         config_commit;
    logic         config_out;
    logic [159:0] in_bus;
    logic [63:0]  out_bus;
    logic         cfg_loaded;
    logic         cfg_ack;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        en;
        logic        din;
        logic        com;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        el;
        logic        ea;
        logic        eo;
    } vec_t;

    vec_t tbl[$];

    fullyconn_nxm_dbuf #(.size(32), .NIN(5), .NOUT(2)) dut (
        .config_clk    (config_clk),
        .config_reset  (config_reset),
        .config_in     (config_in),
        .config_en     (config_en),
        .config_commit (config_commit),
        .config_out    (config_out),
        .in_bus        (in_bus),
        .out_bus       (out_bus),
        .cfg_loaded    (cfg_loaded),
        .cfg_ack       (cfg_ack)
    );

    always #5 config_clk = ~config_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                           input logic el, input logic ea, input logic eo);
        chk({tag, ".out0"}, out_bus[31:0], e0);
        chk({tag, ".out1"}, out_bus[63:32], e1);
        chk({tag, ".loaded"}, {31'b0, cfg_loaded}, {31'b0, el});
        chk({tag, ".ack"}, {31'b0, cfg_ack}, {31'b0, ea});
        chk({tag, ".cfg_out"}, {31'b0, config_out}, {31'b0, eo});
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic din, input logic com);
        @(negedge config_clk);
        config_en     = en;
        config_in     = din;
        config_commit = com;
        @(posedge config_clk);
        #1;
    endtask

    task automatic add(input logic en, input logic din, input logic com,
                       input logic [31:0] e0, input logic [31:0] e1,
                       input logic el, input logic ea, input logic eo);
        vec_t v;
        v.en = en; v.din = din; v.com = com;
        v.e0 = e0; v.e1 = e1; v.el = el; v.ea = ea; v.eo = eo;
        tbl.push_back(v);
    endtask

    initial begin
        logic pat [12];
        logic exp_co;

        config_reset  = 1'b1;
        config_en     = 1'b0;
        config_in     = 1'b0;
        config_commit = 1'b0;
        in_bus        = {I4, I3, I2, I1, I0};

        // Stream: load sel1=4, sel0=2 and commit.
        add(1,1,0, I0,I0, 0,0,0);
        add(1,0,0, I0,I0, 0,0,0);
        add(1,0,0, I0,I0, 0,0,0);
        add(1,0,0, I0,I0, 0,0,0);
        add(1,1,0, I0,I0, 0,0,0);
        add(1,0,0, I0,I0, 1,0,1);
        add(0,0,1, I2,I4, 0,1,1);
        add(0,0,0, I2,I4, 0,0,1);
        // Background reload sel1=0, sel0=5 (drive zero).
        add(1,0,0, I2,I4, 0,0,0);
        add(1,0,0, I2,I4, 0,0,0);
        add(1,0,0, I2,I4, 0,0,0);
        add(1,1,0, I2,I4, 0,0,1);
        add(1,0,0, I2,I4, 0,0,0);
        add(1,1,0, I2,I4, 1,0,0);
        add(0,0,1, Z, I0, 0,1,0);
        add(0,0,0, Z, I0, 0,0,0);
        // Early commit after 4 bits is ignored; sel1=3, sel0=1.
        add(1,0,0, Z, I0, 0,0,0);
        add(1,1,0, Z, I0, 0,0,0);
        add(1,1,0, Z, I0, 0,0,1);
        add(1,0,0, Z, I0, 0,0,0);
        add(0,0,1, Z, I0, 0,0,0);
        add(1,0,0, Z, I0, 0,0,1);
        add(1,1,0, Z, I0, 1,0,0);
        add(0,0,1, I1,I3, 0,1,0);
        add(0,0,0, I1,I3, 0,0,0);
        // Out-of-range selects sel1=6, sel0=7 drive zero.
        add(1,1,0, I1,I3, 0,0,1);
        add(1,1,0, I1,I3, 0,0,1);
        add(1,0,0, I1,I3, 0,0,0);
        add(1,1,0, I1,I3, 0,0,0);
        add(1,1,0, I1,I3, 0,0,1);
        add(1,1,0, I1,I3, 1,0,1);
        add(0,0,1, Z, Z,  0,1,1);
        add(0,0,0, Z, Z,  0,0,1);

        // Reset state
        #2;
        chk_all("reset", I0, I0, 0, 0, 0);
        @(negedge config_clk);
        config_reset = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].din, tbl[i].com);
            chk_all($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].el, tbl[i].ea, tbl[i].eo);
        end

        // Simultaneous commit + shift: load sel1=4, sel0=2 first.
        step(1,1,0); step(1,0,0); step(1,0,0); step(1,0,0); step(1,1,0); step(1,0,0);
        chk("sim.loaded_pre", {31'b0, cfg_loaded}, 32'd1);
        step(1,1,1);
        chk_all("sim.commit", I2, I4, 0, 1, 0);
        // Held commit: counter is 1, so this cycle is not accepted.
        step(0,0,1);
        chk_all("sim.hold", I2, I4, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1,0,0);
        chk("sim.cnt5_loaded", {31'b0, cfg_loaded}, 32'd0);
        step(1,0,0);
        chk("sim.cnt6_loaded", {31'b0, cfg_loaded}, 32'd1);

        // Chain passthrough with gaps, then saturation + commit.
        @(negedge config_clk);
        config_en = 1'b0; config_commit = 1'b0;
        config_reset = 1'b1;
        @(negedge config_clk);
        config_reset = 1'b0;
        pat = '{1,0,1,1,0,0, 0,1,1,0,1,0};
        for (int i = 0; i < 12; i++) begin
            exp_co = (i >= 5) ? pat[i-5] : 1'b0;
            step(1, pat[i], 0);
            chk($sformatf("chain.shift%0d", i), {31'b0, config_out}, {31'b0, exp_co});
            if (i % 2 == 1) begin
                step(0, ~pat[i], 0);
                chk($sformatf("chain.gap%0d", i), {31'b0, config_out}, {31'b0, exp_co});
            end
        end
        chk("chain.saturated_loaded", {31'b0, cfg_loaded}, 32'd1);
        step(0,0,1);
        chk_all("chain.commit", I2, I3, 0, 1, 0);

        // Asynchronous reset in the middle of a shift sequence.
        step(1,1,0); step(1,1,0); step(1,1,0);
        #2;
        config_reset = 1'b1;
        #1;
        chk_all("areset", I0, I0, 0, 0, 0);
        @(negedge config_clk);
        config_reset = 1'b0;
        step(0,0,1);
        chk_all("areset.after", I0, I0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fullyconn_nxm_dbuf.md
Name: fullyconn_nxm_dbuf

Overview:
Parametrised N-input, M-output fully connected switch cell for the CGRA routing fabric. Each output independently selects any input, or drives zero. Configuration loads serially through the standard config chain into a shadow register. It is copied to the active register only on an explicit commit, so the fabric can be reconfigured in the background without glitching live routes. A bit counter reports when a full configuration word has been shifted in.

Parameters:
size, 32, data width of each input/output port in bits
NIN, 5, number of data inputs (>=2)
NOUT, 2, number of data outputs (>=1)
SELW, $clog2(NIN+1), select field width per output (derived, not overridden)
CW, NOUT*SELW, total config chain length in bits (derived)

Ports:
config_clk  input  1  single clock for all sequential state
config_reset  input  1  asynchronous, active-high reset
config_in  input  1  serial config data in
config_en  input  1  shift enable for the shadow chain
config_commit  input  1  copy shadow to active (single-cycle request)
config_out  output  1  serial config data out (chain continuation)
in_bus  input  NIN*size  input k occupies bits [k*size +: size]
out_bus  output  NOUT*size  output j occupies bits [j*size +: size]
cfg_loaded  output  1  high when exactly CW bits have been shifted since reset or last accepted commit
cfg_ack  output  1  registered one-cycle pulse: commit accepted

Behaviour:
- Reset, asynchronous, while config_reset=1:
  - shadow=0, active=0, bit counter=0.
  - cfg_loaded=0, cfg_ack=0.
  - config_out=0.
  - out_bus = every output driving in0.
- Shift: on a config_clk rising edge with config_en=1:
  - shadow <= {shadow[CW-2:0], config_in}.
  - Counter increments and saturates at CW.
  - config_en=0 holds shadow and counter.
- config_out = shadow[CW-1], combinational from the register. Chain latency through the block is exactly CW enabled shifts.
- The first bit shifted ends at shadow[CW-1]. Output j's select field is active[j*SELW +: SELW], MSB first in the stream.
- cfg_loaded = (counter == CW), combinational from counter.
- Commit: at an edge with config_commit=1 and cfg_loaded=1:
  - active <= shadow (pre-edge value).
  - counter <= 0, or 1 if config_en=1 in the same cycle; that shift still happens.
  - cfg_ack=1 for the following cycle.
- Commit with cfg_loaded=0: ignored. active, counter and shadow are unchanged apart from any shift; cfg_ack stays 0.
- Shifting more than CW bits: counter stays at CW. Shadow holds the last CW bits, so a later commit is still accepted.
- config_commit held high for several cycles: only the first cycle is accepted, because the counter clears. Further acceptance requires CW new shifts.
- Datapath, purely combinational from active: out_j = in_sel when sel < NIN, else 0. No data latency.
- Any select value >= NIN outputs all-zero. Reserved value NIN is the documented "drive zero" code.
- Reset asserted mid-load or mid-commit aborts everything. All state returns to reset values immediately, with no partial commit.

Test Plan:
- Reset: NIN=5, NOUT=2, size=32; in0=0xA5A5A5A5, others distinct -> out0=out1=0xA5A5A5A5; cfg_loaded=0, cfg_ack=0, config_out=0.
- Load and commit, CW=6: shift 1,0,0,0,1,0 (sel1=4, sel0=2) -> cfg_loaded=1 after the 6th edge, outputs still in0. Pulse commit -> next cycle out0=in2, out1=in4, cfg_ack=1 for exactly one cycle, cfg_loaded=0.
- Background reload: after the above, shift 6 bits encoding sel0=5, sel1=0 without commit -> outputs unchanged. Commit -> out0=0, out1=in0.
- Early commit: shift 4 bits, assert commit -> active unchanged, cfg_ack=0. Shift 2 more and commit -> accepted.
- Chain passthrough: shift a 12-bit pattern -> config_out reproduces the first 6 bits delayed by exactly 6 enabled edges. Gaps with config_en=0 insert no bits.
- Simultaneous commit+shift when loaded -> active takes the pre-edge shadow, counter=1. Reset asserted mid-shift asynchronously clears outputs to in0 before the next clock edge.
